// File: rtl/rx_sync_sample_mux.sv
// Receive-side sample source select plus master/slave multi-board sync generator.
// Emits a single-cycle sync_rx that resets the receive datapath on every board at once.
module rx_sync_sample_mux #(
   parameter int NCHAN      = 8,
   parameter int CNT_WIDTH  = 32,
   parameter int SYNC_DELAY = 3
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 enable_rx,
   input  logic                 hb_strobe,
   input  logic [1:0]           mode,
   input  logic                 is_master,
   input  logic                 sync_arm,
   input  logic                 slave_sync_in,
   output logic                 sync_out,
   output logic                 sync_rx,
   output logic [1:0]           sync_state,
   input  logic [16*NCHAN-1:0]  ch_in,
   input  logic [15:0]          loop_i,
   input  logic [15:0]          loop_q,
   input  logic                 loop_strobe,
   output logic [16*NCHAN-1:0]  ch_out,
   output logic [CNT_WIDTH-1:0] sample_count
);

   localparam int W     = CNT_WIDTH / 16;
   localparam int DLY_W = (SYNC_DELAY < 2) ? 1 : $clog2(SYNC_DELAY);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_FIRE  = 2'd2;

   generate
      if (NCHAN < 2 || NCHAN > 16 || (NCHAN % 2) != 0) begin : g_bad_nchan
         $error("rx_sync_sample_mux: NCHAN must be even and within 2..16");
      end
      if (CNT_WIDTH < 16 || CNT_WIDTH > 64 || (CNT_WIDTH % 16) != 0) begin : g_bad_cnt
         $error("rx_sync_sample_mux: CNT_WIDTH must be a multiple of 16 within 16..64");
      end
      if (NCHAN < W + 2) begin : g_bad_fit
         $error("rx_sync_sample_mux: NCHAN too small to carry the counter words plus ch_in[0..1]");
      end
      if (SYNC_DELAY < 1) begin : g_bad_delay
         $error("rx_sync_sample_mux: SYNC_DELAY must be at least 1");
      end
   endgenerate

   logic [1:0]           state_q,  state_d;
   logic                 master_q, master_d;
   logic [DLY_W-1:0]     dly_q,    dly_d;
   logic                 sync_out_q, sync_out_d;
   logic                 sync_rx_q,  sync_rx_d;
   logic                 s1_q, s2_q, s3_q;
   logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;
   logic [15:0]          dbg_q,    dbg_d;
   logic [15:0]          li_q,     lq_q;
   logic [16*NCHAN-1:0]  ch_out_q, ch_out_d;

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      master_d = master_q;
      dly_d    = dly_q;
      case (state_q)
         ST_IDLE: begin
            if (sync_arm) begin
               state_d  = ST_ARMED;
               master_d = is_master;
               dly_d    = '0;
            end
         end
         ST_ARMED: begin
            if (!enable_rx) begin
               state_d = ST_IDLE;
            end else if (master_q) begin
               if (dly_q == DLY_W'(SYNC_DELAY - 1)) state_d = ST_FIRE;
               else                                 dly_d   = dly_q + 1'b1;
            end else if (s2_q && !s3_q) begin
               state_d = ST_FIRE;
            end
         end
         ST_FIRE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Registered from next-state so the io pin and datapath reset never glitch.
   assign sync_out_d = (state_d == ST_ARMED) && master_d;
   assign sync_rx_d  = (state_d == ST_FIRE);

   always_comb begin
      cnt_d = cnt_q;
      dbg_d = dbg_q;
      if (!enable_rx || state_q == ST_FIRE) begin
         cnt_d = '0;
         dbg_d = '0;
      end else if (hb_strobe) begin
         cnt_d = cnt_q + 1'b1;
         dbg_d = dbg_q + 16'd2;
      end
   end

   always_comb begin
      ch_out_d = ch_in;
      case (mode)
         2'd1: begin
            ch_out_d[15:0]  = li_q;
            ch_out_d[31:16] = lq_q;
         end
         2'd2: begin
            ch_out_d[15:0]  = dbg_q;
            ch_out_d[31:16] = dbg_q + 16'd1;
         end
         2'd3: begin
            // Most-significant counter word lands in channel 0.
            for (int k = 0; k < W; k++) begin
               ch_out_d[16*k +: 16] = cnt_q[16*(W-1-k) +: 16];
            end
            ch_out_d[16*(NCHAN-2) +: 16] = ch_in[15:0];
            ch_out_d[16*(NCHAN-1) +: 16] = ch_in[31:16];
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         master_q   <= 1'b0;
         dly_q      <= '0;
         sync_out_q <= 1'b0;
         sync_rx_q  <= 1'b0;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
         cnt_q      <= '0;
         dbg_q      <= '0;
         li_q       <= '0;
         lq_q       <= '0;
         ch_out_q   <= '0;
      end else begin
         state_q    <= state_d;
         master_q   <= master_d;
         dly_q      <= dly_d;
         sync_out_q <= sync_out_d;
         sync_rx_q  <= sync_rx_d;
         s1_q       <= slave_sync_in;
         s2_q       <= s1_q;
         s3_q       <= s2_q;
         cnt_q      <= cnt_d;
         dbg_q      <= dbg_d;
         if (loop_strobe) begin
            li_q <= loop_i;
            lq_q <= loop_q;
         end
         ch_out_q   <= ch_out_d;
      end
   end

   assign sync_out     = sync_out_q;
   assign sync_rx      = sync_rx_q;
   assign sync_state   = state_q;
   assign ch_out       = ch_out_q;
   assign sample_count = cnt_q;

endmodule

// File: tb/tb_rx_sync_sample_mux.sv
// Bench for rx_sync_sample_mux: a master and a slave instance cross-wired through sync_out.
// Table-driven channel-mux vectors plus hand-written sync and counter sequences.
module tb_rx_sync_sample_mux;

   localparam int NCH = 8;
   localparam int CW  = 32;

   logic             clock = 1'b0;
   logic             reset_n;
   logic             enable_rx, hb_strobe, loop_strobe;
   logic [1:0]       mode;
   logic             sync_arm_m, sync_arm_s, tb_sync;
   logic [16*NCH-1:0] ch_in;
   logic [15:0]      loop_i, loop_q;

   logic             m_sync_out, m_sync_rx, s_sync_out, s_sync_rx, s_sync_in;
   logic [1:0]       m_state, s_state;
   logic [16*NCH-1:0] m_ch_out, s_ch_out;
   logic [CW-1:0]    m_count, s_count;

   assign s_sync_in = m_sync_out | tb_sync;

   always #5 clock = ~clock;

   rx_sync_sample_mux #(.NCHAN(NCH), .CNT_WIDTH(CW), .SYNC_DELAY(3)) u_master (
      .clock(clock), .reset_n(reset_n), .enable_rx(enable_rx), .hb_strobe(hb_strobe),
      .mode(mode), .is_master(1'b1), .sync_arm(sync_arm_m), .slave_sync_in(1'b0),
      .sync_out(m_sync_out), .sync_rx(m_sync_rx), .sync_state(m_state),
      .ch_in(ch_in), .loop_i(loop_i), .loop_q(loop_q), .loop_strobe(loop_strobe),
      .ch_out(m_ch_out), .sample_count(m_count)
   );

   rx_sync_sample_mux #(.NCHAN(NCH), .CNT_WIDTH(CW), .SYNC_DELAY(3)) u_slave (
      .clock(clock), .reset_n(reset_n), .enable_rx(enable_rx), .hb_strobe(hb_strobe),
      .mode(mode), .is_master(1'b0), .sync_arm(sync_arm_s), .slave_sync_in(s_sync_in),
      .sync_out(s_sync_out), .sync_rx(s_sync_rx), .sync_state(s_state),
      .ch_in(ch_in), .loop_i(loop_i), .loop_q(loop_q), .loop_strobe(loop_strobe),
      .ch_out(s_ch_out), .sample_count(s_count)
   );

   typedef struct {
      logic [1:0]  mode;
      logic        ls;
      logic [15:0] li, lq;
      logic [7:0]  seed;
      logic [15:0] e0, e1, e2, e6, e7;
   } vec_t;

   typedef struct {
      int          idx;
      logic [15:0] e0, e1, e2, e6, e7;
   } exp_t;

   vec_t vecs [8];
   exp_t sb [$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [16*NCH-1:0] mk_ch(input logic [7:0] seed);
      logic [16*NCH-1:0] v;
      for (int k = 0; k < NCH; k++) v[16*k +: 16] = {seed, 8'(k)};
      return v;
   endfunction

   function automatic logic [15:0] chan(input logic [16*NCH-1:0] v, input int k);
      return v[16*k +: 16];
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      exp_t e;
      reset_n = 1'b0; enable_rx = 1'b0; hb_strobe = 1'b0; loop_strobe = 1'b0;
      mode = 2'd0; sync_arm_m = 1'b0; sync_arm_s = 1'b0; tb_sync = 1'b0;
      ch_in = '0; loop_i = '0; loop_q = '0;

      // Loopback latches feed ch_out one cycle after loop_strobe captures them.
      vecs[0] = '{2'd0, 1'b0, 16'h0000, 16'h0000, 8'hA0, 16'hA000, 16'hA001, 16'hA002, 16'hA006, 16'hA007};
      vecs[1] = '{2'd1, 1'b1, 16'h1234, 16'h5678, 8'hB0, 16'h0000, 16'h0000, 16'hB002, 16'hB006, 16'hB007};
      vecs[2] = '{2'd1, 1'b0, 16'hFFFF, 16'hFFFF, 8'hC0, 16'h1234, 16'h5678, 16'hC002, 16'hC006, 16'hC007};
      vecs[3] = '{2'd2, 1'b0, 16'h0000, 16'h0000, 8'hD0, 16'h0000, 16'h0001, 16'hD002, 16'hD006, 16'hD007};
      vecs[4] = '{2'd3, 1'b0, 16'h0000, 16'h0000, 8'hE0, 16'h0000, 16'h0000, 16'hE002, 16'hE000, 16'hE001};
      vecs[5] = '{2'd1, 1'b1, 16'h8001, 16'h7FFE, 8'h11, 16'h1234, 16'h5678, 16'h1102, 16'h1106, 16'h1107};
      vecs[6] = '{2'd0, 1'b0, 16'h0000, 16'h0000, 8'h22, 16'h2200, 16'h2201, 16'h2202, 16'h2206, 16'h2207};
      vecs[7] = '{2'd1, 1'b0, 16'h0000, 16'h0000, 8'h33, 16'h8001, 16'h7FFE, 16'h3302, 16'h3306, 16'h3307};

      #23;
      check("reset m_sync_out", m_sync_out, 0);
      check("reset m_sync_rx", m_sync_rx, 0);
      check("reset m_state", m_state, 0);
      check("reset m_count", m_count, 0);
      check("reset m_ch_out", m_ch_out, 0);
      check("reset s_ch_out", s_ch_out, 0);
      check("reset s_count", s_count, 0);
      @(negedge clock);
      reset_n = 1'b1;
      tick();

      // Channel mux table with counters held clear by enable_rx low.
      for (int i = 0; i < 8; i++) begin
         mode = vecs[i].mode; loop_strobe = vecs[i].ls;
         loop_i = vecs[i].li; loop_q = vecs[i].lq;
         ch_in = mk_ch(vecs[i].seed);
         sb.push_back('{i, vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e6, vecs[i].e7});
         tick();
         e = sb.pop_front();
         check($sformatf("vec%0d ch0", e.idx), chan(m_ch_out, 0), e.e0);
         check($sformatf("vec%0d ch1", e.idx), chan(m_ch_out, 1), e.e1);
         check($sformatf("vec%0d ch2", e.idx), chan(m_ch_out, 2), e.e2);
         check($sformatf("vec%0d ch6", e.idx), chan(m_ch_out, 6), e.e6);
         check($sformatf("vec%0d ch7", e.idx), chan(s_ch_out, 7), e.e7);
      end
      loop_strobe = 1'b0;

      // Debug counter: 5 strobes then disable.
      mode = 2'd2; ch_in = '0; enable_rx = 1'b1; hb_strobe = 1'b1;
      repeat (5) tick();
      hb_strobe = 1'b0;
      tick();
      check("dbg ch0 after 5", chan(m_ch_out, 0), 16'd10);
      check("dbg ch1 after 5", chan(m_ch_out, 1), 16'd11);
      check("count after 5", m_count, 5);
      enable_rx = 1'b0;
      tick();
      check("count cleared by enable", m_count, 0);
      tick();
      check("dbg ch0 cleared", chan(m_ch_out, 0), 16'd0);
      check("dbg ch1 cleared", chan(m_ch_out, 1), 16'd1);

      // Master and slave armed together; re-arms during ARMED and FIRE are ignored.
      mode = 2'd0; enable_rx = 1'b1; hb_strobe = 1'b1;
      sync_arm_m = 1'b1; sync_arm_s = 1'b1;
      tick();
      sync_arm_m = 1'b0; sync_arm_s = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         logic [1:0] exp_st;
         exp_st = (c <= 3) ? 2'd1 : (c == 4) ? 2'd2 : 2'd0;
         check($sformatf("c%0d m_state", c), m_state, exp_st);
         check($sformatf("c%0d s_state", c), s_state, exp_st);
         check($sformatf("c%0d m_sync_out", c), m_sync_out, (c <= 3) ? 1 : 0);
         check($sformatf("c%0d s_sync_out", c), s_sync_out, 0);
         check($sformatf("c%0d m_sync_rx", c), m_sync_rx, (c == 4) ? 1 : 0);
         check($sformatf("c%0d s_sync_rx", c), s_sync_rx, (c == 4) ? 1 : 0);
         check($sformatf("c%0d m_count", c), m_count, (c <= 4) ? c : c - 5);
         sync_arm_m = (c == 2 || c == 4); sync_arm_s = (c == 2 || c == 4);
         tick();
         sync_arm_m = 1'b0; sync_arm_s = 1'b0;
      end
      hb_strobe = 1'b0;

      // Slave alone: external edge first sampled at edge n gives sync_rx after edge n+2.
      sync_arm_s = 1'b1;
      tick();
      sync_arm_s = 1'b0;
      tick();
      check("slave waits armed", s_state, 1);
      tb_sync = 1'b1;
      tick();
      check("slave n rx", s_sync_rx, 0);
      tick();
      check("slave n+1 rx", s_sync_rx, 0);
      check("slave n+1 state", s_state, 1);
      tick();
      check("slave n+2 rx", s_sync_rx, 1);
      check("slave n+2 state", s_state, 2);
      tick();
      check("slave n+3 rx", s_sync_rx, 0);
      check("slave n+3 state", s_state, 0);
      tb_sync = 1'b0;
      repeat (3) tick();

      // Slave armed then disabled: later edge must not fire.
      sync_arm_s = 1'b1;
      tick();
      sync_arm_s = 1'b0;
      check("abort armed", s_state, 1);
      enable_rx = 1'b0;
      tick();
      check("abort idle", s_state, 0);
      enable_rx = 1'b1; tb_sync = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         check($sformatf("abort c%0d rx", c), s_sync_rx, 0);
      end
      tb_sync = 1'b0;

      // Asynchronous reset in the middle of master ARMED.
      sync_arm_m = 1'b1;
      tick();
      sync_arm_m = 1'b0;
      tick();
      check("pre-reset sync_out", m_sync_out, 1);
      #2 reset_n = 1'b0;
      #1;
      check("mid reset sync_out", m_sync_out, 0);
      check("mid reset state", m_state, 0);
      check("mid reset sync_rx", m_sync_rx, 0);
      @(negedge clock);
      reset_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         check($sformatf("post reset c%0d rx", c), m_sync_rx, 0);
         check($sformatf("post reset c%0d state", c), m_state, 0);
      end

      // Wide counter past the 16-bit boundary, then the debug counter wrap.
      enable_rx = 1'b0;
      tick();
      enable_rx = 1'b1; mode = 2'd3; ch_in = mk_ch(8'h5A); hb_strobe = 1'b1;
      repeat (65538) tick();
      hb_strobe = 1'b0;
      tick();
      check("wide count", m_count, 32'h0001_0002);
      check("wide ch0", chan(m_ch_out, 0), 16'h0001);
      check("wide ch1", chan(m_ch_out, 1), 16'h0002);
      check("wide ch2", chan(m_ch_out, 2), 16'h5A02);
      check("wide ch6", chan(m_ch_out, 6), 16'h5A00);
      check("wide ch7", chan(m_ch_out, 7), 16'h5A01);
      mode = 2'd2;
      tick();
      check("dbg wrap ch0", chan(m_ch_out, 0), 16'd4);
      check("dbg wrap ch1", chan(m_ch_out, 1), 16'd5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
